// File: rtl/nv_nvdla_cmac_reg_pkg.sv
// Purpose : Shared constants for the CMAC register blocks. It holds the
//           address-space split, the OP_ENABLE offset, the group status
//           encodings and a helper that derives a group's status.
// Ports   : none (package).
package nv_nvdla_cmac_reg_pkg;

    // Offsets below this value belong to the single (non-ping-pong) group.
    localparam logic [11:0] S_SPACE_END  = 12'h008;
    // OP_ENABLE register inside a data group; bit0 is op_en.
    localparam logic [11:0] OP_EN_OFFSET = 12'h008;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    // A group owned by the consumer is running when enabled. Any other
    // enabled group is queued behind it.
    function automatic logic [1:0] group_status(input logic op_en, input logic is_consumer);
        if (!op_en) begin
            return ST_IDLE;
        end
        return is_consumer ? ST_RUNNING : ST_PENDING;
    endfunction

endpackage

// File: rtl/nv_nvdla_cmac_reg_group_ctrl_if.sv
// Purpose : CSB register port bundle between the bus host and the CMAC
//           group controller.
// Signals : reg_offset  (12) register offset
//           reg_wr_data (32) write data
//           reg_wr_en   (1)  single-cycle write strobe
//           reg_rd_data (32) combinational read data back to the host
// Modports: master = CSB host, slave = register controller.
interface nv_nvdla_cmac_reg_group_ctrl_if;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] reg_rd_data;

    modport master (
        output reg_offset,
        output reg_wr_data,
        output reg_wr_en,
        input  reg_rd_data
    );

    modport slave (
        input  reg_offset,
        input  reg_wr_data,
        input  reg_wr_en,
        output reg_rd_data
    );
endinterface

// File: rtl/nv_nvdla_cmac_reg_op_en_flop.sv
// Purpose : Per-group op_en flop. A group may only be enabled while it is
//           idle. It is cleared when the datapath reports done on it. When
//           an enable write and a done clear land in the same cycle, the
//           enable write wins.
// Ports   : clk, rstn   clock / async active-low reset
//           set_req     OP_ENABLE write aimed at this group
//           set_val     written bit0
//           clr_req     accepted done on this group
//           op_en       registered op_en
//           op_en_nxt   next-state value, so the top can look ahead
module nv_nvdla_cmac_reg_op_en_flop (
    input  logic clk,
    input  logic rstn,
    input  logic set_req,
    input  logic set_val,
    input  logic clr_req,
    output logic op_en,
    output logic op_en_nxt
);

    logic op_en_q;
    logic op_en_d;

    always_comb begin
        op_en_d = op_en_q;
        if (clr_req) begin
            op_en_d = 1'b0;
        end
        // An enabled group ignores OP_ENABLE writes. The exception is the
        // cycle in which its done clear lands: the group is leaving the
        // enabled state then, so the re-enable is accepted and overrides
        // the clear.
        if (set_req && (!op_en_q || clr_req)) begin
            op_en_d = set_val;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_en_q <= 1'b0;
        end else begin
            op_en_q <= op_en_d;
        end
    end

    assign op_en     = op_en_q;
    assign op_en_nxt = op_en_d;

endmodule

// File: rtl/nv_nvdla_cmac_reg_group_ctrl.sv
// Purpose : Ping-pong register group controller for CMAC. It decodes CSB
//           accesses to the single group or to data group D0/D1 (selected
//           by producer). It owns per-group op_en, the consumer pointer and
//           the group status. It drives reg2dp_op_en with a forced
//           one-cycle gap after every accepted done.
// Ports   : nvdla_core_clk / nvdla_core_rstn  clock, async active-low reset
//           csb                       CSB register port (slave modport)
//           s_reg_wr_en/s_reg_rd_data single-register block access
//           dN_reg_wr_en/dN_reg_rd_data data group config access
//           producer                  group targeted by CSB group accesses
//           consumer                  group the datapath executes
//           status_0/status_1         per-group status
//           dp2reg_done               layer-complete pulse
//           d0_op_en/d1_op_en         per-group op_en
//           reg2dp_op_en              registered datapath enable
module nv_nvdla_cmac_reg_group_ctrl
    import nv_nvdla_cmac_reg_pkg::*;
(
    input  logic                                nvdla_core_clk,
    input  logic                                nvdla_core_rstn,
    nv_nvdla_cmac_reg_group_ctrl_if.slave       csb,
    output logic                                s_reg_wr_en,
    input  logic [31:0]                         s_reg_rd_data,
    output logic                                d0_reg_wr_en,
    output logic                                d1_reg_wr_en,
    input  logic [31:0]                         d0_reg_rd_data,
    input  logic [31:0]                         d1_reg_rd_data,
    input  logic                                producer,
    output logic                                consumer,
    output logic [1:0]                          status_0,
    output logic [1:0]                          status_1,
    input  logic                                dp2reg_done,
    output logic                                d0_op_en,
    output logic                                d1_op_en,
    output logic                                reg2dp_op_en
);

    logic is_single;
    logic is_op_en;
    logic grp_wr;
    logic set0_req;
    logic set1_req;
    logic clr0_req;
    logic clr1_req;
    logic done_accepted;
    logic d0_op_en_nxt;
    logic d1_op_en_nxt;
    logic consumer_q;
    logic consumer_d;
    logic reg2dp_op_en_q;
    logic reg2dp_op_en_d;
    logic unused_wr_data;

    // Only bit0 of the write data matters here. The config registers
    // consume the full word.
    assign unused_wr_data = ^csb.reg_wr_data[31:1];

    // ---------------- address decode ----------------
    assign is_single = (csb.reg_offset < S_SPACE_END);
    assign is_op_en  = (csb.reg_offset == OP_EN_OFFSET);
    assign grp_wr    = csb.reg_wr_en & ~is_single;

    assign s_reg_wr_en  = csb.reg_wr_en & is_single;
    // The config of an enabled group is frozen. OP_ENABLE itself lives here,
    // not in the config block.
    assign d0_reg_wr_en = grp_wr & ~is_op_en & ~producer & ~d0_op_en;
    assign d1_reg_wr_en = grp_wr & ~is_op_en &  producer & ~d1_op_en;

    assign set0_req = grp_wr & is_op_en & ~producer;
    assign set1_req = grp_wr & is_op_en &  producer;

    always_comb begin
        csb.reg_rd_data = s_reg_rd_data;
        if (!is_single) begin
            if (is_op_en) begin
                csb.reg_rd_data = {31'b0, (producer ? d1_op_en : d0_op_en)};
            end else begin
                csb.reg_rd_data = producer ? d1_reg_rd_data : d0_reg_rd_data;
            end
        end
    end

    // ---------------- done handling ----------------
    // A done pulse only counts when the consumer group is actually enabled.
    assign done_accepted = dp2reg_done & (consumer_q ? d1_op_en : d0_op_en);
    assign clr0_req      = done_accepted & ~consumer_q;
    assign clr1_req      = done_accepted &  consumer_q;

    nv_nvdla_cmac_reg_op_en_flop u_d0_op_en (
        .clk       (nvdla_core_clk),
        .rstn      (nvdla_core_rstn),
        .set_req   (set0_req),
        .set_val   (csb.reg_wr_data[0]),
        .clr_req   (clr0_req),
        .op_en     (d0_op_en),
        .op_en_nxt (d0_op_en_nxt)
    );

    nv_nvdla_cmac_reg_op_en_flop u_d1_op_en (
        .clk       (nvdla_core_clk),
        .rstn      (nvdla_core_rstn),
        .set_req   (set1_req),
        .set_val   (csb.reg_wr_data[0]),
        .clr_req   (clr1_req),
        .op_en     (d1_op_en),
        .op_en_nxt (d1_op_en_nxt)
    );

    // ---------------- consumer / datapath enable ----------------
    always_comb begin
        consumer_d = consumer_q ^ done_accepted;
        // Look at the next consumer's next op_en, so an enable write shows up
        // on the very next cycle. After an accepted done, the enable is held
        // low for one cycle so the datapath sees a clean layer boundary.
        reg2dp_op_en_d = ~done_accepted & (consumer_d ? d1_op_en_nxt : d0_op_en_nxt);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            consumer_q     <= 1'b0;
            reg2dp_op_en_q <= 1'b0;
        end else begin
            consumer_q     <= consumer_d;
            reg2dp_op_en_q <= reg2dp_op_en_d;
        end
    end

    assign consumer     = consumer_q;
    assign reg2dp_op_en = reg2dp_op_en_q;
    assign status_0     = group_status(d0_op_en, ~consumer_q);
    assign status_1     = group_status(d1_op_en,  consumer_q);

endmodule

// File: tb/tb_nv_nvdla_cmac_reg_group_ctrl.sv
// Directed stimulus for the CMAC ping-pong register group controller.
// Expected values are queued with the cycle they apply to. A monitor on
// the falling edge pops and compares them against the DUT.
module tb_nv_nvdla_cmac_reg_group_ctrl;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    localparam int SIG_RD = 0, SIG_CONS = 1, SIG_ST0 = 2, SIG_ST1 = 3, SIG_R2DP = 4,
                   SIG_D0EN = 5, SIG_D1EN = 6, SIG_SWR = 7, SIG_D0WR = 8, SIG_D1WR = 9;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_rd = 32'hA5A5_0001;
    logic [31:0] d0_rd = 32'hD000_0000;
    logic [31:0] d1_rd = 32'hD111_1111;
    logic        producer = 1'b0;
    logic        done = 1'b0;
    logic        s_wr, d0_wr, d1_wr, consumer, d0_en, d1_en, r2dp;
    logic [1:0]  st0, st1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    nv_nvdla_cmac_reg_group_ctrl_if csb_if ();

    nv_nvdla_cmac_reg_group_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .csb             (csb_if),
        .s_reg_wr_en     (s_wr),
        .s_reg_rd_data   (s_rd),
        .d0_reg_wr_en    (d0_wr),
        .d1_reg_wr_en    (d1_wr),
        .d0_reg_rd_data  (d0_rd),
        .d1_reg_rd_data  (d1_rd),
        .producer        (producer),
        .consumer        (consumer),
        .status_0        (st0),
        .status_1        (st1),
        .dp2reg_done     (done),
        .d0_op_en        (d0_en),
        .d1_op_en        (d1_en),
        .reg2dp_op_en    (r2dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_RD:   return csb_if.reg_rd_data;
            SIG_CONS: return {31'b0, consumer};
            SIG_ST0:  return {30'b0, st0};
            SIG_ST1:  return {30'b0, st1};
            SIG_R2DP: return {31'b0, r2dp};
            SIG_D0EN: return {31'b0, d0_en};
            SIG_D1EN: return {31'b0, d1_en};
            SIG_SWR:  return {31'b0, s_wr};
            SIG_D0WR: return {31'b0, d0_wr};
            default:  return {31'b0, d1_wr};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                if (actual(sb[i].sig) !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h",
                             sb[i].name, cyc, actual(sb[i].sig), sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dly, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sig  = sig;
        e.exp  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csb_set(input logic [11:0] off, input logic [31:0] data, input logic wr);
        csb_if.reg_offset  = off;
        csb_if.reg_wr_data = data;
        csb_if.reg_wr_en   = wr;
    endtask

    initial begin
        csb_set(12'h000, 32'h0, 1'b0);
        repeat (3) tick();
        rstn = 1'b1;

        // 1: reset state and a single-group read
        tick();
        n_checks++;
        if (consumer !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_now_consumer: got %b expected 0", consumer);
        end
        n_checks++;
        if (r2dp !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_now_reg2dp: got %b expected 0", r2dp);
        end
        expect_at(0, SIG_RD,   32'hA5A5_0001, "t1_rd_single");
        expect_at(0, SIG_ST0,  0, "t1_status0");
        expect_at(0, SIG_ST1,  0, "t1_status1");
        expect_at(0, SIG_CONS, 0, "t1_consumer");
        expect_at(0, SIG_R2DP, 0, "t1_reg2dp");
        expect_at(0, SIG_D0EN, 0, "t1_d0_op_en");
        expect_at(0, SIG_D1EN, 0, "t1_d1_op_en");

        // 2: enable D0, then done
        tick();
        producer = 1'b0;
        csb_set(12'h008, 32'h1, 1'b1);
        #1;
        n_checks++;
        if (d0_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_now_op_en_wr_no_cfg: got %b expected 0", d0_wr);
        end
        expect_at(0, SIG_D0WR, 0, "t2_op_en_wr_no_cfg");
        expect_at(1, SIG_D0EN, 1, "t2_d0_op_en");
        expect_at(1, SIG_R2DP, 1, "t2_reg2dp_on");
        expect_at(1, SIG_ST0,  1, "t2_status0_run");
        tick();
        csb_set(12'h000, 32'h0, 1'b0);
        done = 1'b1;
        expect_at(1, SIG_ST0,  0, "t2_status0_idle");
        expect_at(1, SIG_CONS, 1, "t2_consumer_tog");
        expect_at(1, SIG_R2DP, 0, "t2_reg2dp_off");
        expect_at(1, SIG_D0EN, 0, "t2_d0_cleared");
        tick();
        done = 1'b0;

        // 3: consumer is D1; enable D1 (running), then D0 (pending), then done
        producer = 1'b1;
        csb_set(12'h008, 32'h1, 1'b1);
        expect_at(1, SIG_D1EN, 1, "t3_d1_op_en");
        expect_at(1, SIG_ST1,  1, "t3_status1_run");
        expect_at(1, SIG_R2DP, 1, "t3_reg2dp_on");
        tick();
        producer = 1'b0;
        csb_set(12'h008, 32'h1, 1'b1);
        expect_at(1, SIG_D0EN, 1, "t3_d0_op_en");
        expect_at(1, SIG_ST0,  2, "t3_status0_pend");
        tick();
        csb_set(12'h000, 32'h0, 1'b0);
        done = 1'b1;
        expect_at(1, SIG_R2DP, 0, "t3_gap_cycle");
        expect_at(1, SIG_CONS, 0, "t3_consumer_tog");
        expect_at(1, SIG_D1EN, 0, "t3_d1_cleared");
        expect_at(2, SIG_R2DP, 1, "t3_pending_start");
        expect_at(2, SIG_ST0,  1, "t3_status0_run");
        expect_at(2, SIG_ST1,  0, "t3_status1_idle");
        tick();
        done = 1'b0;
        tick();

        // 4: frozen config, ignored disable, readback, decode boundaries
        producer = 1'b0;
        csb_set(12'h010, 32'h1234, 1'b1);
        expect_at(0, SIG_D0WR, 0, "t4_d0_frozen");
        expect_at(0, SIG_D1WR, 0, "t4_d1_not_sel");
        expect_at(0, SIG_SWR,  0, "t4_s_not_sel");
        tick();
        csb_set(12'h008, 32'h0, 1'b1);
        expect_at(1, SIG_D0EN, 1, "t4_disable_ignored");
        tick();
        csb_set(12'h008, 32'h0, 1'b0);
        expect_at(0, SIG_RD, 32'h0000_0001, "t4_rd_op_en_d0");
        tick();
        csb_set(12'h010, 32'h0, 1'b0);
        expect_at(0, SIG_RD, 32'hD000_0000, "t4_rd_cfg_d0");
        tick();
        producer = 1'b1;
        expect_at(0, SIG_RD, 32'hD111_1111, "t4_rd_cfg_d1");
        csb_set(12'h010, 32'h55, 1'b1);
        expect_at(0, SIG_D1WR, 1, "t4_d1_cfg_wr");
        expect_at(0, SIG_D0WR, 0, "t4_d0_no_wr");
        tick();
        csb_set(12'h008, 32'h0, 1'b0);
        expect_at(0, SIG_RD, 32'h0, "t4_rd_op_en_d1");
        tick();
        csb_set(12'h007, 32'h9, 1'b1);
        expect_at(0, SIG_SWR,  1, "t4_s_wr_boundary");
        expect_at(0, SIG_D1WR, 0, "t4_d1_no_wr_single");
        expect_at(0, SIG_RD,   32'hA5A5_0001, "t4_rd_single_007");
        tick();
        csb_set(12'h000, 32'h0, 1'b0);

        // 5: ignored done, then same-cycle done + re-enable
        done = 1'b1;
        expect_at(1, SIG_CONS, 1, "t5_consumer_to_d1");
        expect_at(1, SIG_D0EN, 0, "t5_d0_cleared");
        tick();
        expect_at(1, SIG_CONS, 1, "t5_done_ignored");
        expect_at(1, SIG_R2DP, 0, "t5_reg2dp_idle");
        tick();
        done = 1'b0;
        producer = 1'b1;
        csb_set(12'h008, 32'h1, 1'b1);
        expect_at(1, SIG_D1EN, 1, "t5_d1_op_en");
        expect_at(1, SIG_R2DP, 1, "t5_reg2dp_on");
        tick();
        done = 1'b1;
        csb_set(12'h008, 32'h1, 1'b1);
        expect_at(1, SIG_D1EN, 1, "t5_set_wins");
        expect_at(1, SIG_CONS, 0, "t5_consumer_tog");
        expect_at(1, SIG_ST1,  2, "t5_status1_pend");
        expect_at(1, SIG_R2DP, 0, "t5_gap_cycle");
        tick();
        done = 1'b0;
        csb_set(12'h000, 32'h0, 1'b0);

        // 6: D0 running with D1 pending, then asynchronous reset
        producer = 1'b0;
        csb_set(12'h008, 32'h1, 1'b1);
        expect_at(1, SIG_D0EN, 1, "t6_d0_op_en");
        expect_at(1, SIG_ST0,  1, "t6_status0_run");
        expect_at(1, SIG_ST1,  2, "t6_status1_pend");
        expect_at(1, SIG_R2DP, 1, "t6_reg2dp_on");
        tick();
        csb_set(12'h000, 32'h0, 1'b0);
        tick();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (consumer !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_now_consumer: got %b expected 0", consumer);
        end
        n_checks++;
        if (d0_en !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_now_d0_op_en: got %b expected 0", d0_en);
        end
        n_checks++;
        if (d1_en !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_now_d1_op_en: got %b expected 0", d1_en);
        end
        n_checks++;
        if (r2dp !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_now_reg2dp: got %b expected 0", r2dp);
        end
        expect_at(0, SIG_CONS, 0, "t6_rst_consumer");
        expect_at(0, SIG_D0EN, 0, "t6_rst_d0_op_en");
        expect_at(0, SIG_D1EN, 0, "t6_rst_d1_op_en");
        expect_at(0, SIG_R2DP, 0, "t6_rst_reg2dp");
        expect_at(0, SIG_ST0,  0, "t6_rst_status0");
        expect_at(0, SIG_ST1,  0, "t6_rst_status1");
        tick();
        rstn = 1'b1;
        repeat (3) tick();

        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, expected 0x%08h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
